// File: rtl/prpg_lfsr_hd_engine.sv
// rtl/prpg_lfsr_hd_engine.sv - command-driven Galois LFSR pattern generator with Hamming-distance statistics
module prpg_lfsr_hd_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic [WIDTH-1:0]           cmd_data,
    output logic [WIDTH-1:0]           pattern,
    output logic                       pattern_valid,
    output logic [$clog2(WIDTH+1)-1:0] hd,
    output logic [CNT_W-1:0]           hd_sum,
    output logic [CNT_W-1:0]           run_cnt,
    output logic [CNT_W-1:0]           hd_avg,
    output logic                       avg_valid,
    output logic                       busy,
    output logic                       err,
    output logic                       halted
);
    localparam int HD_W = $clog2(WIDTH+1);
    localparam int DC_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    localparam logic [2:0] OP_CONFIG = 3'd1, OP_SEED = 3'd2, OP_RUN = 3'd3, OP_AVG = 3'd4,
                           OP_CLEAR  = 3'd5, OP_HALT = 3'd6, OP_RSVD = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DIV} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] tap;
    logic [WIDTH-1:0] remaining;
    logic [DC_W-1:0]  div_cnt;
    logic [CNT_W-1:0] div_rem, div_quo;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] t);
        logic [WIDTH-1:0] n;
        n[0] = p[WIDTH-1];
        for (int i = 1; i < WIDTH; i++) n[i] = p[i-1] ^ (t[i] & p[WIDTH-1]);
        return n;
    endfunction

    function automatic logic [HD_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [HD_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) c = c + HD_W'(v[i]);
        return c;
    endfunction

    logic             accept, do_step, div_last, div_ge;
    logic [WIDTH-1:0] step_nxt;
    logic [HD_W-1:0]  hd_nxt;
    logic [CNT_W:0]   sum_ext, cnt_ext, rem_sh, rem_diff;
    logic [CNT_W-1:0] quo_nxt, rem_nxt;

    assign accept   = cmd_valid && cmd_ready;
    assign step_nxt = lfsr_step(pattern, tap);
    assign hd_nxt   = popcount(pattern ^ step_nxt);
    assign sum_ext  = {1'b0, hd_sum} + {{(CNT_W+1-HD_W){1'b0}}, hd_nxt};
    assign cnt_ext  = {1'b0, run_cnt} + 1'b1;
    assign do_step  = (accept && cmd_op == OP_RUN && cmd_data != '0) ||
                      (state == S_RUN && remaining != '0);

    // Restoring divider: hd_sum is shifted through div_quo, run_cnt is frozen during DIV.
    assign rem_sh   = {div_rem, div_quo[CNT_W-1]};
    assign rem_diff = rem_sh - {1'b0, run_cnt};
    assign div_ge   = !rem_diff[CNT_W];
    assign quo_nxt  = {div_quo[CNT_W-2:0], div_ge};
    assign rem_nxt  = div_ge ? rem_diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
    assign div_last = (div_cnt == DC_W'(CNT_W-1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) begin
                if (cmd_op == OP_RUN && cmd_data != '0)     state_nxt = S_RUN;
                else if (cmd_op == OP_AVG && run_cnt != '0) state_nxt = S_DIV;
            end
            S_RUN:   if (remaining == '0) state_nxt = S_IDLE;
            S_DIV:   if (div_last)        state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == S_IDLE) && !halted;
        busy      = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tap <= '0; pattern <= '0; pattern_valid <= 1'b0; hd <= '0;
            hd_sum <= '0; run_cnt <= '0; hd_avg <= '0; avg_valid <= 1'b0;
            err <= 1'b0; halted <= 1'b0; remaining <= '0;
            div_cnt <= '0; div_rem <= '0; div_quo <= '0;
        end else begin
            pattern_valid <= 1'b0;
            avg_valid     <= 1'b0;
            if (do_step) begin
                pattern       <= step_nxt;
                hd            <= hd_nxt;
                pattern_valid <= 1'b1;
                if (sum_ext[CNT_W]) begin hd_sum <= '1; err <= 1'b1; end
                else                      hd_sum <= sum_ext[CNT_W-1:0];
                if (cnt_ext[CNT_W]) begin run_cnt <= '1; err <= 1'b1; end
                else                      run_cnt <= cnt_ext[CNT_W-1:0];
            end
            if (state == S_RUN && remaining != '0) remaining <= remaining - 1'b1;
            if (state == S_DIV) begin
                div_rem <= rem_nxt;
                div_quo <= quo_nxt;
                div_cnt <= div_cnt + 1'b1;
                if (div_last) begin hd_avg <= quo_nxt; avg_valid <= 1'b1; end
            end
            if (accept) begin
                case (cmd_op)
                    OP_CONFIG: tap <= cmd_data;
                    OP_SEED: begin
                        if (cmd_data != '0) begin
                            pattern <= cmd_data; pattern_valid <= 1'b1; hd <= '0;
                        end else err <= 1'b1;
                    end
                    OP_RUN: if (cmd_data != '0) remaining <= cmd_data - 1'b1;
                    OP_AVG: begin
                        if (run_cnt == '0) begin
                            hd_avg <= '0; avg_valid <= 1'b1; err <= 1'b1;
                        end else begin
                            div_rem <= '0; div_quo <= hd_sum; div_cnt <= '0;
                        end
                    end
                    OP_CLEAR: begin
                        hd_sum <= '0; run_cnt <= '0; hd_avg <= '0; hd <= '0; err <= 1'b0;
                    end
                    OP_HALT: halted <= 1'b1;
                    OP_RSVD: err <= 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prpg_lfsr_hd_engine.sv
// tb/tb_prpg_lfsr_hd_engine.sv - directed bench for prpg_lfsr_hd_engine (CNT_W=16 and CNT_W=4 instances)
module tb_prpg_lfsr_hd_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_valid = 0, a_ready, a_pv, a_av, a_busy, a_err, a_halt;
    logic [2:0] a_op = 0;
    logic [7:0] a_data = 0, a_pat;
    logic [3:0] a_hd;
    logic [15:0] a_sum, a_cnt, a_avg;

    logic       b_valid = 0, b_ready, b_pv, b_av, b_busy, b_err, b_halt;
    logic [2:0] b_op = 0;
    logic [7:0] b_data = 0, b_pat;
    logic [3:0] b_hd;
    logic [3:0] b_sum, b_cnt, b_avg;

    prpg_lfsr_hd_engine #(.WIDTH(8), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_op(a_op),
        .cmd_data(a_data), .pattern(a_pat), .pattern_valid(a_pv), .hd(a_hd), .hd_sum(a_sum),
        .run_cnt(a_cnt), .hd_avg(a_avg), .avg_valid(a_av), .busy(a_busy), .err(a_err), .halted(a_halt));

    prpg_lfsr_hd_engine #(.WIDTH(8), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_op(b_op),
        .cmd_data(b_data), .pattern(b_pat), .pattern_valid(b_pv), .hd(b_hd), .hd_sum(b_sum),
        .run_cnt(b_cnt), .hd_avg(b_avg), .avg_valid(b_av), .busy(b_busy), .err(b_err), .halted(b_halt));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for ready, presents one command for one edge; returns 1 ns after acceptance.
    task automatic send(input bit which, input logic [2:0] op, input logic [7:0] d);
        for (int i = 0; i < 50; i++) begin
            if ((which ? b_ready : a_ready) === 1'b1) break;
            tick();
        end
        chk("ready_before_send", which ? b_ready : a_ready, 1);
        if (which) begin b_valid = 1; b_op = op; b_data = d; end
        else       begin a_valid = 1; a_op = op; a_data = d; end
        tick();
        a_valid = 0; b_valid = 0;
    endtask

    int n, steps, first_ret, zero_seen;

    initial begin
        tick(); tick();
        rst = 0;
        chk("rst_pattern", a_pat, 0);
        chk("rst_stats", {a_sum, a_cnt}, 0);
        chk("rst_avg_hd", {a_avg, a_hd}, 0);
        chk("rst_flags", {a_err, a_halt, a_busy, a_pv, a_av, a_ready}, 6'b000001);

        send(0, 3'd1, 8'h1D);
        send(0, 3'd2, 8'h01);
        chk("seed_pattern", a_pat, 8'h01);
        chk("seed_pv_hd", {a_pv, a_hd}, 5'b1_0000);

        send(0, 3'd3, 8'd7);
        for (int i = 1; i <= 7; i++) begin
            chk($sformatf("run7_pat%0d", i), a_pat, 32'h1 << i);
            chk($sformatf("run7_hd_pv_busy%0d", i), {a_hd, a_pv, a_busy}, 6'b0010_1_1);
            tick();
        end
        chk("run7_done_busy_pv", {a_busy, a_pv}, 0);
        chk("run7_hd_sum", a_sum, 14);
        chk("run7_run_cnt", a_cnt, 7);

        send(0, 3'd3, 8'd1);
        chk("run1_pat", a_pat, 8'h1D);
        chk("run1_hd", a_hd, 5);
        chk("run1_busy", a_busy, 1);
        tick();
        chk("run1_busy_end", a_busy, 0);
        chk("run1_sum_cnt", {a_sum, a_cnt}, {16'd19, 16'd8});

        send(0, 3'd4, 8'd0);
        chk("div_busy", a_busy, 1);
        n = 1;
        while (a_av !== 1'b1 && n < 40) begin
            chk("div_pattern_frozen", a_pat, 8'h1D);
            tick();
            n++;
        end
        chk("avg_latency", n, 17);
        chk("avg_value", a_avg, 2);
        tick();
        chk("avg_pulse_end_busy", {a_av, a_busy}, 0);

        send(0, 3'd2, 8'h00);
        chk("seed0_err", a_err, 1);
        chk("seed0_pattern_kept", {a_pat, a_pv}, {8'h1D, 1'b0});
        send(0, 3'd5, 8'h00);
        chk("clear_err_stats", {a_err, a_sum, a_cnt, a_avg}, 0);
        chk("clear_pattern_kept", a_pat, 8'h1D);
        send(0, 3'd4, 8'h00);
        chk("avg0_pulse_value", {a_av, a_avg}, {1'b1, 16'd0});
        chk("avg0_err_busy", {a_err, a_busy}, 2'b10);
        send(0, 3'd5, 8'h00);
        send(0, 3'd7, 8'h00);
        chk("rsvd_err", a_err, 1);
        chk("rsvd_no_effect", {a_pat, a_sum, a_busy}, {8'h1D, 16'd0, 1'b0});
        send(0, 3'd5, 8'h00);

        send(0, 3'd2, 8'h01);
        send(0, 3'd3, 8'hFF);
        steps = 0; first_ret = 0; zero_seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (a_busy !== 1'b1) break;
            if (a_pv === 1'b1) begin
                steps++;
                if (a_pat == 8'h00) zero_seen++;
                if (a_pat == 8'h01 && first_ret == 0) first_ret = steps;
            end
            tick();
        end
        chk("run255_steps", steps, 255);
        chk("run255_first_return", first_ret, 255);
        chk("run255_zero_seen", zero_seen, 0);
        chk("run255_run_cnt", a_cnt, 255);
        chk("run255_err", a_err, 0);

        send(0, 3'd3, 8'd10);
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("midrst_pattern_sum", {a_pat, a_sum, a_cnt}, 0);
        chk("midrst_busy_ready", {a_busy, a_ready, a_pv}, 3'b010);
        send(0, 3'd1, 8'h1D);
        send(0, 3'd2, 8'h01);
        send(0, 3'd3, 8'd2);
        chk("rerun_pat1", a_pat, 8'h02);
        tick();
        chk("rerun_pat2", a_pat, 8'h04);
        tick();
        chk("rerun_done", {a_busy, a_cnt, a_sum}, {1'b0, 16'd2, 16'd4});

        send(1, 3'd1, 8'h00);
        send(1, 3'd2, 8'h01);
        send(1, 3'd3, 8'd10);
        for (int i = 1; i <= 10; i++) begin
            chk($sformatf("sat_hd%0d", i), b_hd, 2);
            if (i == 7) chk("sat_pre_sum_err", {b_sum, b_err}, {4'd14, 1'b0});
            if (i == 8) chk("sat_hit_sum_err", {b_sum, b_err}, {4'd15, 1'b1});
            tick();
        end
        chk("sat_final_sum_cnt", {b_sum, b_cnt}, {4'd15, 4'd10});
        chk("sat_final_pat_err", {b_pat, b_err}, {8'h04, 1'b1});

        send(1, 3'd6, 8'h00);
        chk("halt_flags", {b_halt, b_ready}, 2'b10);
        b_valid = 1; b_op = 3'd2; b_data = 8'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halted_ready_low", b_ready, 0);
        end
        b_valid = 0;
        chk("halted_pattern_kept", b_pat, 8'h04);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
